// File: rtl/key_debounce_sync.sv
// key_debounce_sync
//   Conditions raw push-button pins into clean per-key signals for the
//   downstream press filter. Each key is synchronised into CLK, normalised to
//   active-high, debounced with a stability counter, and turned into
//   single-cycle press/release pulses plus auto-repeat pulses while held.
//
// Ports
//   CLK      in   system clock, all logic on posedge
//   RESET    in   synchronous active-high reset
//   KEY_RAW  in   [NKEYS] asynchronous raw key pins
//   LEVEL    out  [NKEYS] debounced key state, 1 = pressed
//   PRESS    out  [NKEYS] one-cycle pulse on LEVEL 0->1
//   RELEASE  out  [NKEYS] one-cycle pulse on LEVEL 1->0
//   REPEAT   out  [NKEYS] one-cycle auto-repeat pulse while held
module key_debounce_sync #(
  parameter int unsigned NKEYS      = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [22:0] STABLE     = 23'd499999,
  parameter logic [25:0] HOLD       = 26'd24999999,
  parameter logic [25:0] RATE       = 26'd4999999
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NKEYS-1:0] KEY_RAW,
  output logic [NKEYS-1:0] LEVEL,
  output logic [NKEYS-1:0] PRESS,
  output logic [NKEYS-1:0] RELEASE,
  output logic [NKEYS-1:0] REPEAT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } state_e;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        repeat_q, repeat_d;
    logic [22:0] dcnt_q, dcnt_d;
    logic [25:0] rcnt_q, rcnt_d;
    state_e      state_q, state_d;
    logic        norm;

    always_comb begin
      sync1_d   = KEY_RAW[g];
      sync2_d   = sync1_q;
      norm      = sync2_q ^ ACTIVE_LOW;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      dcnt_d    = dcnt_q;
      rcnt_d    = rcnt_q;
      state_d   = state_q;

      // Any sample matching the current level restarts the stability count.
      if (norm == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == STABLE) begin
        level_d   = norm;
        dcnt_d    = '0;
        press_d   = norm;
        release_d = ~norm;
      end else begin
        dcnt_d = dcnt_q + 23'd1;
      end

      // The repeat FSM keys off the next LEVEL so that the release cycle itself
      // already forces IDLE and suppresses a coincident repeat expiry, and the
      // HOLD count starts on the same edge that raises PRESS.
      if (!level_d) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (press_d) begin
              rcnt_d  = HOLD;
              state_d = DELAY;
            end
          end
          DELAY: begin
            if (rcnt_q == '0) begin
              if (RATE != '0) begin
                repeat_d = 1'b1;
                rcnt_d   = RATE;
                state_d  = RPT;
              end
            end else begin
              rcnt_d = rcnt_q - 26'd1;
            end
          end
          RPT: begin
            if (rcnt_q == '0) begin
              repeat_d = 1'b1;
              rcnt_d   = RATE;
            end else begin
              rcnt_d = rcnt_q - 26'd1;
            end
          end
          default: begin
            state_d = IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        sync1_q   <= ACTIVE_LOW;
        sync2_q   <= ACTIVE_LOW;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        dcnt_q    <= '0;
        rcnt_q    <= '0;
        state_q   <= IDLE;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        dcnt_q    <= dcnt_d;
        rcnt_q    <= rcnt_d;
        state_q   <= state_d;
      end
    end

    assign LEVEL[g]   = level_q;
    assign PRESS[g]   = press_q;
    assign RELEASE[g] = release_q;
    assign REPEAT[g]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with STABLE=4, HOLD=10, RATE=3,
// ACTIVE_LOW=1. Inputs change just after a posedge; t counts posedges since
// the change, so a press lands at t=7 and the first repeat at t=18.
module tb_key_debounce_sync;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] KEY_RAW;
  logic [3:0] LEVEL, PRESS, RELEASE, REPEAT;

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce_sync #(
    .NKEYS(4),
    .ACTIVE_LOW(1'b1),
    .STABLE(23'd4),
    .HOLD(26'd10),
    .RATE(26'd3)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .KEY_RAW(KEY_RAW),
    .LEVEL(LEVEL),
    .PRESS(PRESS),
    .RELEASE(RELEASE),
    .REPEAT(REPEAT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] bitv(input int k, input bit c);
    logic [3:0] v;
    v = '0;
    v[k] = c;
    return v;
  endfunction

  task automatic expect_out(input string tag, input int t,
                            input logic [3:0] l, input logic [3:0] p,
                            input logic [3:0] r, input logic [3:0] q);
    check($sformatf("%s t=%0d LEVEL", tag, t), LEVEL, l);
    check($sformatf("%s t=%0d PRESS", tag, t), PRESS, p);
    check($sformatf("%s t=%0d RELEASE", tag, t), RELEASE, r);
    check($sformatf("%s t=%0d REPEAT", tag, t), REPEAT, q);
  endtask

  function automatic bit rep_at(input int t, input int last);
    return (t >= 18) && (t <= last) && (((t - 18) % 4) == 0);
  endfunction

  initial begin
    RESET   = 1'b1;
    KEY_RAW = 4'b1111;

    // Reset held for 3 cycles, then 20 idle cycles.
    for (int t = 1; t <= 3; t++) begin
      tick();
      expect_out("reset", t, 4'b0, 4'b0, 4'b0, 4'b0);
    end
    RESET = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expect_out("post_reset", t, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // Clean press of key 0, released before any repeat.
    KEY_RAW[0] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expect_out("clean", t, bitv(0, t >= 7 && t <= 14), bitv(0, t == 7),
                 bitv(0, t == 15), 4'b0);
      if (t == 8) KEY_RAW[0] = 1'b1;
    end

    // Bounce on key 1: 3-cycle runs never reach STABLE+1 samples.
    for (int seg = 0; seg < 10; seg++) begin
      KEY_RAW[1] = (seg % 2) == 1;
      for (int j = 0; j < 3; j++) begin
        tick();
        expect_out("bounce", seg * 3 + j + 1, 4'b0, 4'b0, 4'b0, 4'b0);
      end
    end
    KEY_RAW[1] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      expect_out("bounce_settle", t, bitv(1, t >= 7), bitv(1, t == 7), 4'b0, 4'b0);
    end
    KEY_RAW[1] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      expect_out("bounce_rel", t, bitv(1, t < 7), 4'b0, bitv(1, t == 7), 4'b0);
    end

    // Auto-repeat on key 2: repeats at 18,22,...,50; release at 53.
    KEY_RAW[2] = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      expect_out("repeat", t, bitv(2, t >= 7 && t <= 52), bitv(2, t == 7),
                 bitv(2, t == 53), bitv(2, rep_at(t, 50)));
      if (t == 46) KEY_RAW[2] = 1'b1;
    end

    // Release lands exactly on the repeat expiry at t=54: release wins.
    KEY_RAW[2] = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      expect_out("collide", t, bitv(2, t >= 7 && t <= 53), bitv(2, t == 7),
                 bitv(2, t == 54), bitv(2, rep_at(t, 50)));
      if (t == 47) KEY_RAW[2] = 1'b1;
    end

    // Re-press: a fresh HOLD delay shows the FSM returned to IDLE.
    KEY_RAW[2] = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      tick();
      expect_out("repress", t, bitv(2, t >= 7 && t <= 18), bitv(2, t == 7),
                 bitv(2, t == 19), bitv(2, t == 18));
      if (t == 12) KEY_RAW[2] = 1'b1;
    end

    // Reset at dcnt=2 on key 3 with the pin held low; press after edge 6+6.
    KEY_RAW[3] = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      tick();
      expect_out("mid_reset", t, bitv(3, t >= 12 && t <= 19), bitv(3, t == 12),
                 bitv(3, t == 20), 4'b0);
      if (t == 4) RESET = 1'b1;
      if (t == 5) RESET = 1'b0;
      if (t == 13) KEY_RAW[3] = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
